// File: rtl/mips_mc_seq_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, instruction
// classes, datapath select codes, trap causes and the supported opcode/funct set.
package mips_mc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_JR, C_ILLEGAL
  } iclass_t;

  // npc_sel carries five sources, so it is one bit wider than the other selects
  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_BR  = 3'd1;
  localparam logic [2:0] NPC_JMP = 3'd2;
  localparam logic [2:0] NPC_REG = 3'd3;
  localparam logic [2:0] NPC_EXC = 3'd4;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_RET = 2'd2;

  localparam logic [1:0] MEM2REG_ALU = 2'd0;
  localparam logic [1:0] MEM2REG_RAM = 2'd1;
  localparam logic [1:0] MEM2REG_RET = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_EXT  = 2'd2;
  localparam logic [1:0] SRCB_EXT2 = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_ILL  = 2'd1;
  localparam logic [1:0] CAUSE_BUS  = 2'd2;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

endpackage

// File: rtl/mips_mc_seq_decode.sv
// Combinational instruction classifier: opcode/funct -> class plus the ALU
// operation and immediate-extension mode used in EXEC.
module mips_mc_decode
  import mips_mc_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op
);

  always_comb begin
    iclass = C_ILLEGAL;
    alu_op = ALU_ADD;
    ext_op = EXT_ZERO;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU: begin iclass = C_RTYPE; alu_op = ALU_ADD; end
          FN_SUBU: begin iclass = C_RTYPE; alu_op = ALU_SUB; end
          FN_AND:  begin iclass = C_RTYPE; alu_op = ALU_AND; end
          FN_OR:   begin iclass = C_RTYPE; alu_op = ALU_OR;  end
          FN_SLT:  begin iclass = C_RTYPE; alu_op = ALU_SLT; end
          FN_JR:   iclass = C_JR;
          default: iclass = C_ILLEGAL;
        endcase
      end
      OP_ADDI: begin iclass = C_IMM;    alu_op = ALU_ADD; ext_op = EXT_SIGN; end
      OP_ORI:  begin iclass = C_IMM;    alu_op = ALU_OR;  ext_op = EXT_ZERO; end
      OP_LUI:  begin iclass = C_IMM;    alu_op = ALU_LUI; ext_op = EXT_LUI;  end
      OP_LW:   begin iclass = C_LOAD;   alu_op = ALU_ADD; ext_op = EXT_SIGN; end
      OP_SW:   begin iclass = C_STORE;  alu_op = ALU_ADD; ext_op = EXT_SIGN; end
      OP_BEQ,
      OP_BNE:  begin iclass = C_BRANCH; alu_op = ALU_SUB; ext_op = EXT_SIGN; end
      OP_J:    iclass = C_JUMP;
      OP_JAL:  iclass = C_JAL;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_mc_seq.sv
// Multi-cycle sequencer: steps the shared datapath through FETCH..WB over one
// req/ack memory port, with precise traps and a retired-instruction counter.
module mips_mc_seq
  import mips_mc_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int TO_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [2:0]       npc_sel,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem2reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             exc,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_o
);

  localparam int              TO_LAST_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  iclass_t         iclass;
  logic [2:0]      dec_alu_op;
  logic [1:0]      dec_ext_op;
  logic            is_bne;
  logic            to_hit;

  mips_mc_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass),
    .alu_op (dec_alu_op),
    .ext_op (dec_ext_op)
  );

  assign is_bne  = (opcode == OP_BNE);
  assign state_o = state;
  // This waiting cycle is the MEM_TIMEOUT-th without ack; an ack here would win.
  assign to_hit  = (MEM_TIMEOUT != 0) && !mem_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      retired   <= '0;
      exc_cause <= CAUSE_NONE;
    end else begin
      to_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack)     state <= S_DECODE;
          else if (to_hit) begin state <= S_TRAP; exc_cause <= CAUSE_BUS; end
          else             to_cnt <= to_cnt + 1'b1;
        end
        S_DECODE: begin
          if (iclass == C_ILLEGAL) begin state <= S_TRAP; exc_cause <= CAUSE_ILL; end
          else                     state <= S_EXEC;
        end
        S_EXEC: begin
          case (iclass)
            C_RTYPE, C_IMM:   state <= S_WB;
            C_LOAD, C_STORE:  state <= S_MEM;
            default: begin
              state   <= S_FETCH;
              retired <= retired + 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (iclass == C_STORE) begin
              state   <= S_FETCH;
              retired <= retired + 1'b1;
            end else begin
              state <= S_WB;
            end
          end else if (to_hit) begin
            state     <= S_TRAP;
            exc_cause <= CAUSE_BUS;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WB: begin
          state   <= S_FETCH;
          retired <= retired + 1'b1;
        end
        S_TRAP:  state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    npc_sel   = NPC_SEQ;
    reg_wr    = 1'b0;
    reg_dst   = REGDST_RT;
    mem2reg   = MEM2REG_ALU;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    alu_op    = ALU_ADD;
    ext_op    = EXT_ZERO;
    exc       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          npc_sel = NPC_SEQ;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_EXT2;
        ext_op    = EXT_SIGN;
      end
      S_EXEC: begin
        alu_op = dec_alu_op;
        ext_op = dec_ext_op;
        case (iclass)
          C_RTYPE: alu_src_a = 1'b1;
          C_IMM, C_LOAD, C_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_EXT;
          end
          C_BRANCH: begin
            alu_src_a = 1'b1;
            pc_wr     = zero ^ is_bne;
            npc_sel   = NPC_BR;
          end
          C_JUMP: begin
            pc_wr   = 1'b1;
            npc_sel = NPC_JMP;
          end
          C_JAL: begin
            pc_wr   = 1'b1;
            npc_sel = NPC_JMP;
            reg_wr  = 1'b1;
            reg_dst = REGDST_RET;
            mem2reg = MEM2REG_RET;
          end
          C_JR: begin
            pc_wr   = 1'b1;
            npc_sel = NPC_REG;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (iclass == C_STORE);
      end
      S_WB: begin
        reg_wr  = 1'b1;
        reg_dst = (iclass == C_RTYPE) ? REGDST_RD : REGDST_RT;
        mem2reg = (iclass == C_LOAD) ? MEM2REG_RAM : MEM2REG_ALU;
      end
      S_TRAP: begin
        exc     = 1'b1;
        pc_wr   = 1'b1;
        npc_sel = NPC_EXC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_seq.sv
// Bench for mips_mc_seq: each instruction expands into a queue of per-cycle
// expected outputs (with planned ack timing) that one compare process checks.
module tb_mips_mc_seq;

  localparam int TMO = 16;
  localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                 K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;
  localparam logic [2:0] ST_IDLE = 0, ST_F = 1, ST_D = 2, ST_E = 3, ST_M = 4, ST_W = 5, ST_T = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, mem_ack = 1'b0;
  logic        mem_req, mem_we, iord, ir_wr, pc_wr, reg_wr, alu_src_a, exc;
  logic [2:0]  npc_sel, alu_op, state_o;
  logic [1:0]  reg_dst, mem2reg, alu_src_b, ext_op, exc_cause;
  logic [31:0] retired;

  mips_mc_seq #(.MEM_TIMEOUT(TMO), .CNT_W(32), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .npc_sel(npc_sel), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .exc(exc), .exc_cause(exc_cause), .retired(retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ack, zero; logic [5:0] op, fn; logic [2:0] st;
    logic mem_req, mem_we, iord, ir_wr, pc_wr; logic [2:0] npc;
    logic reg_wr; logic [1:0] rdst, m2r; logic a; logic [1:0] b;
    logic [2:0] aop; logic [1:0] eop; logic exc; logic [1:0] cause; logic [31:0] ret;
  } rec_t;

  rec_t q[$];
  rec_t exp_r;
  logic chk_en = 1'b0;
  int   n_chk = 0, n_err = 0;
  int   m_ret = 0, m_cause = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] st, input logic [5:0] op, input logic [5:0] fn);
    rec_t r;
    r = '{default: '0};
    r.st = st; r.op = op; r.fn = fn;
    r.ack = 1'($urandom); r.zero = 1'($urandom);
    r.ret = 32'(m_ret); r.cause = 2'(m_cause);
    return r;
  endfunction

  // Expand one instruction into its cycle-by-cycle expected behaviour.
  task automatic gen(input logic [5:0] op, fn, input int kind, input logic [2:0] aop,
                     input logic [1:0] eop, input logic z, input int fw, mw);
    rec_t r;
    int nf = (fw >= TMO) ? TMO : fw;
    for (int i = 0; i < nf; i++) begin
      r = mk(ST_F, op, fn); r.ack = 0; r.mem_req = 1; q.push_back(r);
    end
    if (fw >= TMO) begin
      m_cause = 2; r = mk(ST_T, op, fn); r.exc = 1; r.pc_wr = 1; r.npc = 4; q.push_back(r);
      return;
    end
    r = mk(ST_F, op, fn); r.ack = 1; r.mem_req = 1; r.ir_wr = 1; r.pc_wr = 1; r.npc = 0;
    q.push_back(r);
    r = mk(ST_D, op, fn); r.b = 3; r.eop = 1; q.push_back(r);
    if (kind == K_ILL) begin
      m_cause = 1; r = mk(ST_T, op, fn); r.exc = 1; r.pc_wr = 1; r.npc = 4; q.push_back(r);
      return;
    end
    r = mk(ST_E, op, fn); r.aop = aop; r.eop = eop; r.zero = z;
    case (kind)
      K_R:               r.a = 1;
      K_IMM, K_LW, K_SW: begin r.a = 1; r.b = 2; end
      K_BEQ, K_BNE:      begin r.a = 1; r.npc = 1; r.pc_wr = (kind == K_BEQ) ? z : !z; end
      K_J:               begin r.pc_wr = 1; r.npc = 2; end
      K_JAL:             begin r.pc_wr = 1; r.npc = 2; r.reg_wr = 1; r.rdst = 2; r.m2r = 2; end
      default:           begin r.pc_wr = 1; r.npc = 3; end
    endcase
    q.push_back(r);
    if (kind >= K_BEQ) begin m_ret++; return; end
    if (kind == K_LW || kind == K_SW) begin
      nf = (mw >= TMO) ? TMO : mw;
      for (int i = 0; i < nf; i++) begin
        r = mk(ST_M, op, fn); r.ack = 0; r.mem_req = 1; r.iord = 1; r.mem_we = (kind == K_SW);
        q.push_back(r);
      end
      if (mw >= TMO) begin
        m_cause = 2; r = mk(ST_T, op, fn); r.exc = 1; r.pc_wr = 1; r.npc = 4; q.push_back(r);
        return;
      end
      r = mk(ST_M, op, fn); r.ack = 1; r.mem_req = 1; r.iord = 1; r.mem_we = (kind == K_SW);
      q.push_back(r);
      if (kind == K_SW) begin m_ret++; return; end
    end
    r = mk(ST_W, op, fn); r.reg_wr = 1;
    r.rdst = (kind == K_R) ? 2'd1 : 2'd0; r.m2r = (kind == K_LW) ? 2'd1 : 2'd0;
    q.push_back(r);
    m_ret++;
  endtask

  // Instruction table: 0..14 supported, 15 a random unsupported encoding.
  task automatic instr(input int idx, output logic [5:0] op, fn, output int kind,
                       output logic [2:0] aop, output logic [1:0] eop);
    logic [5:0] bad_op [4];
    bad_op = '{6'h3f, 6'h01, 6'h20, 6'h0c};
    fn = 6'($urandom); aop = 0; eop = 0;
    case (idx)
      0:  begin op = 6'h00; fn = 6'h21; kind = K_R; end
      1:  begin op = 6'h00; fn = 6'h23; kind = K_R; aop = 1; end
      2:  begin op = 6'h00; fn = 6'h24; kind = K_R; aop = 2; end
      3:  begin op = 6'h00; fn = 6'h25; kind = K_R; aop = 3; end
      4:  begin op = 6'h00; fn = 6'h2a; kind = K_R; aop = 4; end
      5:  begin op = 6'h00; fn = 6'h08; kind = K_JR; end
      6:  begin op = 6'h08; kind = K_IMM; eop = 1; end
      7:  begin op = 6'h0d; kind = K_IMM; aop = 3; end
      8:  begin op = 6'h0f; kind = K_IMM; aop = 5; eop = 2; end
      9:  begin op = 6'h23; kind = K_LW; eop = 1; end
      10: begin op = 6'h2b; kind = K_SW; eop = 1; end
      11: begin op = 6'h04; kind = K_BEQ; aop = 1; eop = 1; end
      12: begin op = 6'h05; kind = K_BNE; aop = 1; eop = 1; end
      13: begin op = 6'h02; kind = K_J; end
      14: begin op = 6'h03; kind = K_JAL; end
      default: begin
        kind = K_ILL;
        if ($urandom % 2) begin op = 6'h00; fn = ($urandom % 2) ? 6'h00 : 6'h22; end
        else op = bad_op[$urandom % 4];
      end
    endcase
  endtask

  function automatic int pickw();
    int r = int'($urandom % 24);
    if (r < 18) return r % 4;
    if (r < 21) return TMO - 1;
    return TMO;
  endfunction

  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      opcode = r.op; funct = r.fn; zero = r.zero; mem_ack = r.ack;
      exp_r = r; chk_en = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
  endtask

  task automatic run_random(input int n);
    logic [5:0] op, fn; int kind; logic [2:0] aop; logic [1:0] eop;
    for (int i = 0; i < n; i++) begin
      instr(int'($urandom % 16), op, fn, kind, aop, eop);
      gen(op, fn, kind, aop, eop, 1'($urandom), pickw(), pickw());
      run_queue();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     32'(state_o),   32'(exp_r.st));
      chk("mem_req",   32'(mem_req),   32'(exp_r.mem_req));
      chk("mem_we",    32'(mem_we),    32'(exp_r.mem_we));
      chk("iord",      32'(iord),      32'(exp_r.iord));
      chk("ir_wr",     32'(ir_wr),     32'(exp_r.ir_wr));
      chk("pc_wr",     32'(pc_wr),     32'(exp_r.pc_wr));
      chk("npc_sel",   32'(npc_sel),   32'(exp_r.npc));
      chk("reg_wr",    32'(reg_wr),    32'(exp_r.reg_wr));
      chk("reg_dst",   32'(reg_dst),   32'(exp_r.rdst));
      chk("mem2reg",   32'(mem2reg),   32'(exp_r.m2r));
      chk("alu_src_a", 32'(alu_src_a), 32'(exp_r.a));
      chk("alu_src_b", 32'(alu_src_b), 32'(exp_r.b));
      chk("alu_op",    32'(alu_op),    32'(exp_r.aop));
      chk("ext_op",    32'(ext_op),    32'(exp_r.eop));
      chk("exc",       32'(exc),       32'(exp_r.exc));
      chk("exc_cause", 32'(exc_cause), 32'(exp_r.cause));
      chk("retired",   retired,        exp_r.ret);
    end
  end

  initial begin
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_retired", retired, 0);
    chk("rst_cause", 32'(exc_cause), 0);
    @(posedge clk); #1;
    rst = 1'b1; m_ret = 0; m_cause = 0;
    q.push_back(mk(ST_IDLE, 6'h00, 6'h00));
    run_queue();

    // addu 0x00221821, zero-wait: F,D,E,W
    gen(6'h00, 6'h21, K_R, 3'd0, 2'd0, 1'b0, 0, 0);
    chk("lat_addu", q.size(), 4);
    chk("addu_wb_rdst", 32'(q[3].rdst), 1);
    run_queue();
    chk("addu_retired", retired, 1);

    // lw with 3 MEM wait states
    gen(6'h23, 6'h00, K_LW, 3'd0, 2'd1, 1'b0, 0, 3);
    chk("lat_lw3", q.size(), 8);
    chk("lw_wb_m2r", 32'(q[7].m2r), 1);
    run_queue();

    gen(6'h04, 6'h00, K_BEQ, 3'd1, 2'd1, 1'b0, 0, 0);
    chk("lat_beq", q.size(), 3);
    chk("beq_z0_pc_wr", 32'(q[2].pc_wr), 0);
    run_queue();
    gen(6'h04, 6'h00, K_BEQ, 3'd1, 2'd1, 1'b1, 0, 0);
    chk("beq_z1_pc_wr", 32'(q[2].pc_wr), 1);
    run_queue();

    gen(6'h3f, 6'h00, K_ILL, 3'd0, 2'd0, 1'b0, 0, 0);
    chk("lat_ill", q.size(), 3);
    run_queue();
    chk("ill_cause", 32'(exc_cause), 1);
    chk("ill_retired", retired, 4);

    // fetch timeout: 16 silent cycles then TRAP on the 17th
    gen(6'h00, 6'h21, K_R, 3'd0, 2'd0, 1'b0, TMO, 0);
    chk("lat_tmo", q.size(), 17);
    chk("tmo_trap_st", 32'(q[16].st), 32'(ST_T));
    run_queue();
    chk("tmo_cause", 32'(exc_cause), 2);
    gen(6'h00, 6'h21, K_R, 3'd0, 2'd0, 1'b0, TMO - 1, 0);
    chk("lat_ack16", q.size(), 19);
    run_queue();
    chk("ack16_retired", retired, 5);

    run_random(300);

    // asynchronous reset in the middle of FETCH
    mem_ack = 1'b0;
    chk("pre_rst_state", 32'(state_o), 32'(ST_F));
    chk("pre_rst_req", 32'(mem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_req", 32'(mem_req), 0);
    chk("async_state", 32'(state_o), 0);
    chk("async_retired", retired, 0);
    chk("async_cause", 32'(exc_cause), 0);
    @(posedge clk); #1;
    rst = 1'b1; m_ret = 0; m_cause = 0;
    q.push_back(mk(ST_IDLE, 6'h00, 6'h00));
    run_queue();
    chk("post_rst_fetch", 32'(state_o), 32'(ST_F));
    run_random(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
